// File: rtl/div_share_arbiter.sv
// Shares one radix-2 restoring unsigned divider among NREQ requesters with tagged responses.
// Define DIV_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module div_share_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_num,
  input  logic [NREQ*WIDTH-1:0] req_den,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDX_W-1:0]      resp_id,
  output logic [WIDTH-1:0]      resp_quot,
  output logic [WIDTH-1:0]      resp_rem,
  output logic                  resp_divzero,
  output logic                  busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [IDX_W-1:0] id_q;
  logic             divzero_q;
  logic             resp_valid_q;
  logic             busy_q;
`ifndef DIV_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_q;
`endif

  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_num;
  logic [WIDTH-1:0] gnt_den;
  int unsigned      idx;

  // First valid requester at or after the search start, wrapping modulo NREQ.
  always_comb begin
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_num   = '0;
    gnt_den   = '0;
    idx       = 0;
    if (reset_n && state_q == StIdle) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(rr_q) + k) % NREQ;
`endif
        if (!gnt_found && req_valid[idx]) begin
          gnt_found      = 1'b1;
          gnt_idx        = IDX_W'(idx);
          gnt_num        = req_num[idx*WIDTH +: WIDTH];
          gnt_den        = req_den[idx*WIDTH +: WIDTH];
          req_ready[idx] = 1'b1;
        end
      end
    end
  end

  // Partial remainder is one bit wider than the operands before the trial subtract.
  logic [WIDTH:0] rem_shift;
  logic           rem_ge;
  assign rem_shift = {rem_q, num_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, den_q};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      num_q        <= '0;
      den_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      divzero_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifndef DIV_ARB_FIXED_PRIO_EN
      rr_q         <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_found) begin
            id_q   <= gnt_idx;
            den_q  <= gnt_den;
            busy_q <= 1'b1;
`ifndef DIV_ARB_FIXED_PRIO_EN
            rr_q   <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDX_W'(1);
`endif
            if (gnt_den != '0) begin
              num_q   <= gnt_num;
              rem_q   <= '0;
              cnt_q   <= '0;
              state_q <= StCalc;
            end else begin
              num_q        <= '1;
              rem_q        <= gnt_num;
              divzero_q    <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StDone;
            end
          end
        end
        StCalc: begin
          // Quotient bits shift in behind the consumed numerator bits.
          num_q <= {num_q[WIDTH-2:0], rem_ge};
          rem_q <= rem_ge ? WIDTH'(rem_shift - {1'b0, den_q}) : rem_shift[WIDTH-1:0];
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            divzero_q    <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = id_q;
  assign resp_quot    = num_q;
  assign resp_rem     = rem_q;
  assign resp_divzero = divzero_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: directed vectors, arbitration order,
// backpressure, mid-divide reset and random operands against an arithmetic model.
module tb_div_share_arbiter;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_num = '0;
  logic [NREQ*WIDTH-1:0] req_den = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [IDX_W-1:0]      resp_id;
  logic [WIDTH-1:0]      resp_quot;
  logic [WIDTH-1:0]      resp_rem;
  logic                  resp_divzero;
  logic                  busy;

  div_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_num     (req_num),
    .req_den     (req_den),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_quot   (resp_quot),
    .resp_rem    (resp_rem),
    .resp_divzero(resp_divzero),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned idx;
    logic [15:0] num;
    logic [15:0] den;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        dz;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero gives all ones and the numerator.
  task automatic model(input logic [15:0] n, input logic [15:0] d,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    if (d == 16'd0) begin
      q = 16'hFFFF; r = n; dz = 1'b1;
    end else begin
      q = n / d; r = n % d; dz = 1'b0;
    end
  endtask

  // Full request/response exchange; called and returns mid-cycle (after a negedge).
  task automatic transact(input int unsigned idx, input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz);
    int unsigned c;
    int unsigned lat;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_num[idx*WIDTH +: WIDTH] = n;
    req_den[idx*WIDTH +: WIDTH] = d;
    resp_ready = 1'b0;
    #1;
    c = 0;
    while (!req_ready[idx] && c < 100) begin
      @(negedge clock); #1; c++;
    end
    check("grant", 64'(req_ready), 64'(1 << idx));
    @(negedge clock);
    req_valid = '0;
    #1;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clock); #1; lat++;
    end
    check("latency", 64'(lat), (d == 16'd0) ? 64'd1 : 64'(WIDTH + 1));
    check("resp_id", 64'(resp_id), 64'(idx));
    check("resp_quot", 64'(resp_quot), 64'(eq));
    check("resp_rem", 64'(resp_rem), 64'(er));
    check("resp_divzero", 64'(resp_divzero), 64'(edz));
    check("busy_done", 64'(busy), 64'd1);
    if (d != 16'd0) begin
      check("identity", 64'(32'(d) * 32'(resp_quot) + 32'(resp_rem)), 64'(n));
      check("rem_lt_den", 64'(resp_rem < d), 64'd1);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    check("divzero_clear", 64'(resp_divzero), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_divzero"}, 64'(resp_divzero), 64'd0);
    check({tag, "_id"}, 64'(resp_id), 64'd0);
    check({tag, "_quot"}, 64'(resp_quot), 64'd0);
    check({tag, "_rem"}, 64'(resp_rem), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    int unsigned c;
    logic [3:0]  exp_gnt;
    logic [15:0] n, d, q, r;
    logic        dz;

    vecs[0] = '{idx: 0, num: 16'd1000,   den: 16'd7,      quot: 16'd142,   rem: 16'd6,    dz: 1'b0};
    vecs[1] = '{idx: 2, num: 16'h1234,   den: 16'd0,      quot: 16'hFFFF,  rem: 16'h1234, dz: 1'b1};
    vecs[2] = '{idx: 1, num: 16'hFFFF,   den: 16'd1,      quot: 16'hFFFF,  rem: 16'd0,    dz: 1'b0};
    vecs[3] = '{idx: 3, num: 16'd5,      den: 16'hFFFF,   quot: 16'd0,     rem: 16'd5,    dz: 1'b0};
    vecs[4] = '{idx: 1, num: 16'd0,      den: 16'd5,      quot: 16'd0,     rem: 16'd0,    dz: 1'b0};
    vecs[5] = '{idx: 3, num: 16'hFFFF,   den: 16'hFFFF,   quot: 16'd1,     rem: 16'd0,    dz: 1'b0};

    // Reset with every requester asserting: nothing may be granted.
    req_valid = '1;
    @(negedge clock); @(negedge clock); #1;
    check_reset_outputs("reset");
    req_valid = '0;
    reset_n = 1'b1;
    @(negedge clock);

    // All four requesting continuously: round-robin 0,1,2,3,0 (fixed priority: always 0).
    for (int i = 0; i < 4; i++) begin
      req_num[i*WIDTH +: WIDTH] = 16'(10 + i);
      req_den[i*WIDTH +: WIDTH] = 16'd3;
    end
    req_valid = '1;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      while (req_ready == '0 && c < 100) begin
        @(negedge clock); #1; c++;
      end
`ifdef DIV_ARB_FIXED_PRIO_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'b0001 << (k % 4);
`endif
      check("arb_order", 64'(req_ready), 64'(exp_gnt));
      @(negedge clock); #1;
    end
    req_valid = '0;
    c = 0;
    while (busy && c < 100) begin
      @(negedge clock); #1; c++;
    end
    check("arb_drain", 64'(busy), 64'd0);
    resp_ready = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      transact(vecs[i].idx, vecs[i].num, vecs[i].den, vecs[i].quot, vecs[i].rem, vecs[i].dz);

    // Backpressure: response held for 10 cycles while other requesters wait.
    req_valid = 4'b0010;
    req_num[1*WIDTH +: WIDTH] = 16'hABCD;
    req_den[1*WIDTH +: WIDTH] = 16'd0;
    #1;
    c = 0;
    while (!req_ready[1] && c < 100) begin
      @(negedge clock); #1; c++;
    end
    check("bp_grant", 64'(req_ready), 64'b0010);
    @(negedge clock);
    req_valid = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_quot", 64'(resp_quot), 64'hFFFF);
      check("bp_rem", 64'(resp_rem), 64'hABCD);
      check("bp_id", 64'(resp_id), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      @(negedge clock); #1;
    end
    req_valid = '0;
    resp_ready = 1'b1;
    #1;
    check("bp_no_grant", 64'(req_ready), 64'd0);
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    check("bp_consumed", 64'(resp_valid), 64'd0);

    // Reset during the fifth divide cycle abandons the request.
    req_valid = 4'b0100;
    req_num[2*WIDTH +: WIDTH] = 16'd1000;
    req_den[2*WIDTH +: WIDTH] = 16'd7;
    #1;
    c = 0;
    while (!req_ready[2] && c < 100) begin
      @(negedge clock); #1; c++;
    end
    check("abort_grant", 64'(req_ready), 64'b0100);
    @(negedge clock);
    req_valid = '0;
    repeat (4) @(negedge clock);
    #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    req_valid = '1;
    @(negedge clock); #1;
    check_reset_outputs("abort");
    req_valid = '0;
    reset_n = 1'b1;
    resp_ready = 1'b1;
    c = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock); #1;
      if (resp_valid || busy) c++;
    end
    check("abort_no_resp", 64'(c), 64'd0);
    resp_ready = 1'b0;

    // Random operands on random requesters, some zero and some small denominators.
    for (int i = 0; i < 1000; i++) begin
      n = 16'($urandom);
      d = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) d = 16'd0;
      model(n, d, q, r, dz);
      transact($urandom_range(0, NREQ - 1), n, d, q, r, dz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
